// File: rtl/adc_stream_sequencer.sv
// Readout sequencer: drains per-channel FWFT sample FIFOs into one
// AXI-Stream, one header handshake per packet of at most PKT_LEN beats.
module adc_stream_sequencer #(
    parameter int NUM_CH     = 6,
    parameter int CH_W       = 3,
    parameter int PKT_LEN    = 1024,
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] almost_empty,
    output logic [NUM_CH-1:0] rd_en,
    output logic [CH_W-1:0]   ch_sel,
    input  logic              axis_tready,
    output logic              axis_tvalid,
    output logic              axis_tlast,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [CH_W-1:0]   hdr_ch,
    output logic [15:0]       hdr_seq,
    input  logic              tx_done,
    output logic              busy,
    output logic              frame_done,
    output logic              err_underflow
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES);

    state_t            state_q;
    logic [NUM_CH-1:0] pending_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ch_sel_q;
    logic [15:0]       seq_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  wd_q;
    logic [CNT_W-1:0]  gap_q;
    logic              txd_q;
    logic              err_q;
    logic              hdr_valid_q;
    logic              frame_done_q;

    logic [NUM_CH-1:0] start_pend;
    logic              in_stream;
    logic              ch_empty;
    logic              ch_ae;
    logic              beat;

    // First set bit at or above 'from', wrapping around the channel ring.
    function automatic logic [CH_W-1:0] pick(
        input logic [NUM_CH-1:0] p,
        input logic [CH_W-1:0]   from
    );
        logic [CH_W-1:0] r;
        logic            hit;
        int              idx;
        r   = from;
        hit = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(from) + k) % NUM_CH;
            if (!hit && p[idx]) begin
                r   = CH_W'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign start_pend  = ch_enable & ~empty;
    assign in_stream   = (state_q == STREAM);
    assign ch_empty    = empty[ch_q];
    assign ch_ae       = almost_empty[ch_q];
    assign axis_tvalid = in_stream & ~ch_empty;
    assign axis_tlast  = axis_tvalid & ((cnt_q == LAST_BEAT) | ch_ae);
    assign beat        = axis_tvalid & axis_tready;
    assign rd_en       = beat ? (NUM_CH'(1) << ch_q) : '0;

    assign ch_sel        = ch_sel_q;
    assign hdr_valid     = hdr_valid_q;
    assign hdr_ch        = ch_q;
    assign hdr_seq       = seq_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign err_underflow = err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            ch_q         <= '0;
            ch_sel_q     <= '0;
            seq_q        <= '0;
            cnt_q        <= '0;
            wd_q         <= '0;
            gap_q        <= '0;
            txd_q        <= 1'b0;
            err_q        <= 1'b0;
            hdr_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pending_q <= start_pend;
                        if (|start_pend) begin
                            ch_q        <= pick(start_pend, '0);
                            hdr_valid_q <= 1'b1;
                            state_q     <= HDR;
                        end else begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (hdr_ready) begin
                        seq_q       <= seq_q + 16'd1;
                        cnt_q       <= '0;
                        wd_q        <= '0;
                        hdr_valid_q <= 1'b0;
                        ch_sel_q    <= ch_q;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (tx_done) txd_q <= 1'b1;
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        wd_q  <= '0;
                        if (axis_tlast) begin
                            if (ch_ae) pending_q[ch_q] <= 1'b0;
                            ch_sel_q <= '0;
                            gap_q    <= '0;
                            state_q  <= GAP;
                        end
                    end else if (ch_empty) begin
                        // Starved channel: drop it, leave its packet open.
                        if (wd_q == WD_LAST) begin
                            err_q           <= 1'b1;
                            pending_q[ch_q] <= 1'b0;
                            ch_sel_q        <= '0;
                            gap_q           <= '0;
                            state_q         <= GAP;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (txd_q | tx_done) begin
                        txd_q <= 1'b1;
                        if (gap_q == GAP_END) begin
                            txd_q <= 1'b0;
                            gap_q <= '0;
                            if (|pending_q) begin
                                ch_q        <= pick(pending_q, ch_q);
                                hdr_valid_q <= 1'b1;
                                state_q     <= HDR;
                            end else begin
                                frame_done_q <= 1'b1;
                                state_q      <= IDLE;
                            end
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_stream_sequencer.sv
// Directed bench: FWFT FIFO word-count model plus a negedge stream monitor,
// exercising full frames, long channels, backpressure, masks, stall, reset.
module tb_adc_stream_sequencer;

    localparam int NCH = 6;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic [NCH-1:0] ch_enable;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] almost_empty;
    logic [NCH-1:0] rd_en;
    logic [CHW-1:0] ch_sel;
    logic           axis_tready;
    logic           axis_tvalid;
    logic           axis_tlast;
    logic           hdr_valid;
    logic           hdr_ready;
    logic [CHW-1:0] hdr_ch;
    logic [15:0]    hdr_seq;
    logic           tx_done;
    logic           busy;
    logic           frame_done;
    logic           err_underflow;

    adc_stream_sequencer #(
        .NUM_CH(NCH), .CH_W(CHW), .PKT_LEN(1024), .CNT_W(16),
        .GAP_CYCLES(16), .TIMEOUT(4096)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .ch_enable(ch_enable),
        .empty(empty), .almost_empty(almost_empty), .rd_en(rd_en),
        .ch_sel(ch_sel), .axis_tready(axis_tready),
        .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ch(hdr_ch),
        .hdr_seq(hdr_seq), .tx_done(tx_done), .busy(busy),
        .frame_done(frame_done), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int             cnt [NCH];
    int             fill_val [NCH];
    logic           fill_stb;
    logic [NCH-1:0] stall;
    logic           rnd_tr;
    logic           tr_fix;
    logic           mon_clr;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (fill_stb) cnt[i] <= fill_val[i];
            else if (rd_en[i] && cnt[i] > 0) cnt[i] <= cnt[i] - 1;
        end
    end

    always_comb begin
        empty        = '0;
        almost_empty = '0;
        for (int i = 0; i < NCH; i++) begin
            empty[i]        = (cnt[i] == 0) | stall[i];
            almost_empty[i] = (cnt[i] == 1) & ~stall[i];
        end
    end

    always @(posedge clk) begin
        #1;
        axis_tready = rnd_tr ? 1'($urandom_range(0, 1)) : tr_fix;
    end

    int             hq_ch [$];
    int             hq_seq [$];
    int             last_pos [$];
    int             beats;
    int             rderr;
    int             stab;
    int             fd;
    logic           ptv, ptr, ptl;
    logic [NCH-1:0] exp_rd;

    assign exp_rd = (axis_tvalid && axis_tready) ? (NCH'(1) << ch_sel) : '0;

    always @(negedge clk) begin
        if (mon_clr) begin
            hq_ch.delete();
            hq_seq.delete();
            last_pos.delete();
            beats <= 0;
            rderr <= 0;
            stab  <= 0;
            fd    <= 0;
        end else begin
            if (hdr_valid && hdr_ready) begin
                hq_ch.push_back(int'(hdr_ch));
                hq_seq.push_back(int'(hdr_seq));
            end
            if (axis_tvalid && axis_tready) begin
                beats <= beats + 1;
                if (axis_tlast) last_pos.push_back(beats + 1);
            end
            if (rd_en !== exp_rd || (rd_en & empty) != '0)
                rderr <= rderr + 1;
            if (ptv && !ptr && (!axis_tvalid || axis_tlast != ptl))
                stab <= stab + 1;
            if (frame_done) fd <= fd + 1;
        end
        ptv <= axis_tvalid;
        ptr <= axis_tready;
        ptl <= axis_tlast;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill();
        fill_stb = 1'b1;
        tick();
        fill_stb = 1'b0;
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic go(input logic [NCH-1:0] en);
        ch_enable = en;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_fd(input int budget, input string tag);
        for (int i = 0; i < budget && fd == 0; i++) tick();
        repeat (2) tick();
        chk(tag, fd, 1);
    endtask

    function automatic int qat(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic set_fill(input int a, b, c, d, e, f);
        fill_val[0] = a; fill_val[1] = b; fill_val[2] = c;
        fill_val[3] = d; fill_val[4] = e; fill_val[5] = f;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; ch_enable = '0; stall = '0;
        fill_stb = 1'b0; mon_clr = 1'b0; tx_done = 1'b1;
        hdr_ready = 1'b1; rnd_tr = 1'b0; tr_fix = 1'b1;
        set_fill(0, 0, 0, 0, 0, 0);
        do_fill();
        repeat (3) tick();
        chk("rst_outs", int'({busy, hdr_valid, axis_tvalid, axis_tlast,
            frame_done, err_underflow, rd_en, ch_sel, hdr_ch}), 0);
        chk("rst_seq", int'(hdr_seq), 0);
        rstn = 1'b1;
        tick();

        // all six channels, 10 words each
        set_fill(10, 10, 10, 10, 10, 10);
        do_fill();
        clr();
        go(6'h3F);
        wait_fd(5000, "t1_frame_done");
        chk("t1_nhdr", hq_ch.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_hch%0d", i), qat(hq_ch, i), i);
            chk($sformatf("t1_seq%0d", i), qat(hq_seq, i), i);
            chk($sformatf("t1_last%0d", i), qat(last_pos, i), 10 * (i + 1));
        end
        chk("t1_nlast", last_pos.size(), 6);
        chk("t1_beats", beats, 60);
        chk("t1_rd", rderr, 0);
        chk("t1_busy", int'(busy), 0);

        // one long channel split at PKT_LEN
        set_fill(0, 0, 2500, 0, 0, 0);
        do_fill();
        clr();
        go(6'h04);
        wait_fd(8000, "t2_frame_done");
        chk("t2_nhdr", hq_ch.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_hch%0d", i), qat(hq_ch, i), 2);
            chk($sformatf("t2_seq%0d", i), qat(hq_seq, i), 6 + i);
        end
        chk("t2_last0", qat(last_pos, 0), 1024);
        chk("t2_last1", qat(last_pos, 1), 2048);
        chk("t2_last2", qat(last_pos, 2), 2500);
        chk("t2_nlast", last_pos.size(), 3);
        chk("t2_rem", cnt[2], 0);

        // random backpressure
        set_fill(37, 0, 0, 0, 21, 0);
        do_fill();
        clr();
        rnd_tr = 1'b1;
        go(6'h11);
        wait_fd(5000, "t3_frame_done");
        rnd_tr = 1'b0;
        tick();
        chk("t3_beats", beats, 58);
        chk("t3_stable", stab, 0);
        chk("t3_rd", rderr, 0);
        chk("t3_last0", qat(last_pos, 0), 37);
        chk("t3_last1", qat(last_pos, 1), 58);
        chk("t3_hch1", qat(hq_ch, 1), 4);
        chk("t3_rem", cnt[0] + cnt[4], 0);

        // enable mask, ch2 empty at start, gap waits on tx_done
        set_fill(5, 5, 0, 5, 5, 5);
        do_fill();
        clr();
        tx_done = 1'b0;
        go(6'b100101);
        for (int i = 0; i < 500 && last_pos.size() == 0; i++) tick();
        repeat (100) tick();
        chk("t4_gap_hold", hq_ch.size(), 1);
        tx_done = 1'b1;
        wait_fd(2000, "t4_frame_done");
        chk("t4_nhdr", hq_ch.size(), 2);
        chk("t4_hch0", qat(hq_ch, 0), 0);
        chk("t4_hch1", qat(hq_ch, 1), 5);
        chk("t4_beats", beats, 10);
        chk("t4_untouched", cnt[1] + cnt[3] + cnt[4], 15);

        // ch1 starves mid-packet
        set_fill(0, 10, 0, 10, 0, 0);
        do_fill();
        clr();
        go(6'b001010);
        for (int i = 0; i < 500 && cnt[1] > 6; i++) tick();
        stall[1] = 1'b1;
        wait_fd(6000, "t5_frame_done");
        chk("t5_err", int'(err_underflow), 1);
        chk("t5_nhdr", hq_ch.size(), 2);
        chk("t5_hch1", qat(hq_ch, 1), 3);
        chk("t5_beats", beats, 14);
        chk("t5_nlast", last_pos.size(), 1);
        chk("t5_last0", qat(last_pos, 0), 14);
        chk("t5_ch1_left", cnt[1], 6);
        stall = '0;

        // reset mid-packet, then an exact PKT_LEN channel
        set_fill(50, 0, 0, 0, 0, 0);
        do_fill();
        clr();
        go(6'h01);
        for (int i = 0; i < 500 && cnt[0] > 40; i++) tick();
        rstn = 1'b0;
        tick();
        chk("t6_rst_outs", int'({busy, hdr_valid, axis_tvalid, axis_tlast,
            frame_done, err_underflow, rd_en, ch_sel, hdr_ch}), 0);
        chk("t6_rst_seq", int'(hdr_seq), 0);
        chk("t6_no_tlast", last_pos.size(), 0);
        rstn = 1'b1;
        set_fill(1024, 0, 0, 0, 0, 0);
        do_fill();
        clr();
        go(6'h01);
        wait_fd(4000, "t6_frame_done");
        chk("t6_nhdr", hq_ch.size(), 1);
        chk("t6_seq0", qat(hq_seq, 0), 0);
        chk("t6_nlast", last_pos.size(), 1);
        chk("t6_last0", qat(last_pos, 0), 1024);
        chk("t6_err", int'(err_underflow), 0);
        chk("t6_rd", rderr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
